// File: rtl/commit_unit.sv
// commit_unit: in-order retirement of the ROB head with store release, regfile write,
// taken-branch flush and the RVFI retirement order counter.
module commit_unit #(
    parameter int ROB_IDX_W = 5,
    parameter int ORDER_W   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 head_valid,
    input  logic                 head_done,
    input  logic [ROB_IDX_W-1:0] head_rob_idx,
    input  logic [31:0]          head_pc,
    input  logic [4:0]           head_rd_addr,
    input  logic [31:0]          head_rd_data,
    input  logic                 head_regf_we,
    input  logic                 head_is_store,
    input  logic                 head_is_branch,
    input  logic                 head_br_en,
    input  logic [31:0]          head_pc_new,
    input  logic                 st_commit_ready_i,
    output logic                 dequeue_o,
    output logic                 st_commit_valid_o,
    output logic                 regf_we_o,
    output logic [4:0]           regf_rd_o,
    output logic [31:0]          regf_data_o,
    output logic [ROB_IDX_W-1:0] regf_rob_idx_o,
    output logic                 commit_valid_o,
    output logic [31:0]          commit_pc_o,
    output logic [ORDER_W-1:0]   order_o,
    output logic                 flush_o,
    output logic [31:0]          redirect_pc_o
);
    typedef enum logic [1:0] {RUN, STORE_WAIT, FLUSH} state_e;

    state_e               state_q;
    logic [ORDER_W-1:0]   cnt_q;
    logic                 regf_we_q;
    logic [4:0]           regf_rd_q;
    logic [31:0]          regf_data_q;
    logic [ROB_IDX_W-1:0] regf_rob_idx_q;
    logic                 commit_valid_q;
    logic [31:0]          commit_pc_q;
    logic [ORDER_W-1:0]   order_q;
    logic                 flush_q;
    logic [31:0]          redirect_pc_q;

    logic retireable;
    logic mispredict;

    assign retireable = head_valid && head_done && state_q == RUN;
    assign mispredict = head_is_branch && head_br_en && !head_is_store;

    // rst gates the combinational handshake so a pending store is dropped at once
    assign st_commit_valid_o = !rst && ((retireable && head_is_store) || state_q == STORE_WAIT);
    assign dequeue_o = !rst && ((retireable && (!head_is_store || st_commit_ready_i)) ||
                                (state_q == STORE_WAIT && st_commit_ready_i));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RUN;
            cnt_q          <= '0;
            regf_we_q      <= 1'b0;
            regf_rd_q      <= '0;
            regf_data_q    <= '0;
            regf_rob_idx_q <= '0;
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
            order_q        <= '0;
            flush_q        <= 1'b0;
            redirect_pc_q  <= '0;
        end else begin
            regf_we_q      <= dequeue_o && head_regf_we && !head_is_store && head_rd_addr != 5'd0;
            regf_rd_q      <= dequeue_o ? head_rd_addr : 5'd0;
            regf_data_q    <= dequeue_o ? head_rd_data : 32'd0;
            regf_rob_idx_q <= dequeue_o ? head_rob_idx : '0;
            commit_valid_q <= dequeue_o;
            commit_pc_q    <= dequeue_o ? head_pc : 32'd0;
            order_q        <= dequeue_o ? cnt_q : '0;
            cnt_q          <= dequeue_o ? cnt_q + ORDER_W'(1) : cnt_q;
            flush_q        <= dequeue_o && mispredict;
            redirect_pc_q  <= (dequeue_o && mispredict) ? head_pc_new : 32'd0;
            // FLUSH blocks retirement for exactly the cycle flush_o is high
            state_q        <= (state_q == FLUSH)                        ? RUN :
                              (dequeue_o && mispredict)                 ? FLUSH :
                              (st_commit_valid_o && !st_commit_ready_i) ? STORE_WAIT : RUN;
        end
    end

    assign regf_we_o      = regf_we_q;
    assign regf_rd_o      = regf_rd_q;
    assign regf_data_o    = regf_data_q;
    assign regf_rob_idx_o = regf_rob_idx_q;
    assign commit_valid_o = commit_valid_q;
    assign commit_pc_o    = commit_pc_q;
    assign order_o        = order_q;
    assign flush_o        = flush_q;
    assign redirect_pc_o  = redirect_pc_q;
endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: drives commit_unit from a queue-based ROB model and checks every
// cycle against expectations derived from the retirement rules.
module tb_commit_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        head_valid, head_done, head_regf_we, head_is_store, head_is_branch, head_br_en;
    logic [4:0]  head_rob_idx, head_rd_addr;
    logic [31:0] head_pc, head_rd_data, head_pc_new;
    logic        st_commit_ready_i;
    logic        dequeue_o, st_commit_valid_o, regf_we_o, commit_valid_o, flush_o;
    logic [4:0]  regf_rd_o, regf_rob_idx_o;
    logic [31:0] regf_data_o, commit_pc_o, redirect_pc_o;
    logic [63:0] order_o;

    commit_unit dut (
        .clk(clk), .rst(rst),
        .head_valid(head_valid), .head_done(head_done), .head_rob_idx(head_rob_idx),
        .head_pc(head_pc), .head_rd_addr(head_rd_addr), .head_rd_data(head_rd_data),
        .head_regf_we(head_regf_we), .head_is_store(head_is_store),
        .head_is_branch(head_is_branch), .head_br_en(head_br_en), .head_pc_new(head_pc_new),
        .st_commit_ready_i(st_commit_ready_i),
        .dequeue_o(dequeue_o), .st_commit_valid_o(st_commit_valid_o),
        .regf_we_o(regf_we_o), .regf_rd_o(regf_rd_o), .regf_data_o(regf_data_o),
        .regf_rob_idx_o(regf_rob_idx_o), .commit_valid_o(commit_valid_o),
        .commit_pc_o(commit_pc_o), .order_o(order_o), .flush_o(flush_o),
        .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, data, pcn;
        logic [4:0]  rd, idx;
        bit          we, st, br, ben, done;
    } ent_t;

    ent_t        rob[$];
    int          checks = 0, errors = 0;
    bit          rmode = 0, rdy = 1, in_flush = 0;
    logic [63:0] cnt = 0;
    logic [4:0]  tail = 0;
    logic        e_we = 0, e_cv = 0, e_fl = 0;
    logic [4:0]  e_rd = 0, e_idx = 0;
    logic [31:0] e_data = 0, e_pc = 0, e_rpc = 0;
    logic [63:0] e_ord = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_regs();
        chk("regf_we", regf_we_o, e_we);
        chk("regf_rd", regf_rd_o, e_rd);
        chk("regf_data", regf_data_o, e_data);
        chk("regf_rob_idx", regf_rob_idx_o, e_idx);
        chk("commit_valid", commit_valid_o, e_cv);
        chk("commit_pc", commit_pc_o, e_pc);
        chk("order", order_o, e_ord);
        chk("flush", flush_o, e_fl);
        chk("redirect_pc", redirect_pc_o, e_rpc);
    endtask

    task automatic clear_exp();
        {e_we, e_cv, e_fl, e_rd, e_idx, e_data, e_pc, e_rpc, e_ord} = '0;
    endtask

    task automatic push(input logic [31:0] pc, data, pcn, input logic [4:0] rd,
                        input bit we, st, br, ben, done);
        ent_t e;
        e.pc = pc; e.data = data; e.pcn = pcn; e.rd = rd; e.idx = tail;
        e.we = we; e.st = st; e.br = br; e.ben = ben; e.done = done;
        tail++;
        rob.push_back(e);
    endtask

    task automatic push_rand();
        int k = $urandom_range(3);
        push($urandom, $urandom, $urandom, 5'($urandom_range(7)), $urandom_range(3) != 0,
             k == 2, k == 3, k == 3 && $urandom_range(1) == 1, $urandom_range(1) == 1);
    endtask

    // One clock: present the head, check the combinational handshake, then the registered result.
    task automatic cycle();
        ent_t h;
        bit   v, can, deq, stv;
        v = rob.size() > 0;
        h = v ? rob[0] : '{default: '0};
        if (rmode) rdy = $urandom_range(2) != 0;
        head_valid = v; head_done = h.done; head_rob_idx = h.idx; head_pc = h.pc;
        head_rd_addr = h.rd; head_rd_data = h.data; head_regf_we = h.we;
        head_is_store = h.st; head_is_branch = h.br; head_br_en = h.ben; head_pc_new = h.pcn;
        st_commit_ready_i = rdy;
        #2;
        can = v && h.done && !in_flush;
        stv = can && h.st;
        deq = can && (!h.st || rdy);
        chk("dequeue", dequeue_o, deq);
        chk("st_valid", st_commit_valid_o, stv);
        e_cv = deq;
        e_we = deq && h.we && !h.st && h.rd != 0;
        e_rd = deq ? h.rd : 5'd0;
        e_data = deq ? h.data : 32'd0;
        e_idx = deq ? h.idx : 5'd0;
        e_pc = deq ? h.pc : 32'd0;
        e_ord = deq ? cnt : 64'd0;
        e_fl = deq && h.br && h.ben;
        e_rpc = e_fl ? h.pcn : 32'd0;
        @(posedge clk);
        #1;
        chk_regs();
        if (deq) begin
            void'(rob.pop_front());
            cnt++;
        end
        if (in_flush) rob.delete();
        in_flush = e_fl;
        if (rmode) begin
            if (rob.size() > 0 && !rob[0].done) rob[0].done = $urandom_range(1) == 1;
            if (rob.size() < 4 && $urandom_range(3) != 0) push_rand();
        end
    endtask

    initial begin
        {head_valid, head_done, head_regf_we, head_is_store, head_is_branch, head_br_en} = '0;
        {head_rob_idx, head_rd_addr, head_pc, head_rd_data, head_pc_new} = '0;
        st_commit_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        head_valid = 1'b1; head_done = 1'b1;
        #1;
        chk("rst_dequeue", dequeue_o, 1'b0);
        chk("rst_st_valid", st_commit_valid_o, 1'b0);
        chk_regs();
        rst = 1'b0;
        // three back-to-back ALU retirements
        push(32'h100, 32'hA, 0, 5'd1, 1, 0, 0, 0, 1);
        push(32'h104, 32'hB, 0, 5'd2, 1, 0, 0, 0, 1);
        push(32'h108, 32'hC, 0, 5'd3, 1, 0, 0, 0, 1);
        repeat (4) cycle();
        // write to x0 is suppressed but still retires
        push(32'h10c, 32'h55, 0, 5'd0, 1, 0, 0, 0, 1);
        repeat (2) cycle();
        // store stalled four cycles, then an ALU head
        push(32'h110, 32'h77, 0, 5'd5, 1, 1, 0, 0, 1);
        push(32'h114, 32'hD, 0, 5'd4, 1, 0, 0, 0, 1);
        rdy = 0;
        repeat (4) cycle();
        rdy = 1;
        repeat (3) cycle();
        // taken jal with a done younger entry behind it
        push(32'h118, 32'h104, 32'h200, 5'd1, 1, 0, 1, 1, 1);
        push(32'h11c, 32'hE, 0, 5'd6, 1, 0, 0, 0, 1);
        repeat (4) cycle();
        // reset while a store waits
        push(32'h120, 32'h88, 0, 5'd0, 0, 1, 0, 0, 1);
        rdy = 0;
        repeat (2) cycle();
        rst = 1'b1;
        #1;
        clear_exp();
        chk("rstw_st_valid", st_commit_valid_o, 1'b0);
        chk("rstw_dequeue", dequeue_o, 1'b0);
        chk_regs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rob.delete();
        cnt = 0;
        in_flush = 0;
        rdy = 1;
        push(32'h124, 32'h99, 0, 5'd7, 1, 0, 0, 0, 1);
        repeat (2) cycle();
        rmode = 1;
        repeat (3000) cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/commit_unit.md
# commit_unit

In-order retirement stage directly downstream of the 32-entry reorder buffer. Each cycle it inspects the ROB head entry and, once that entry is complete, retires it:
- dequeues it;
- writes the architectural register file;
- releases stores to memory with a valid/ready handshake;
- on a taken branch (predict-not-taken front end), raises the pipeline-wide flush with the redirect PC.

It also keeps the 64-bit retirement order counter used by RVFI.

## Interface
Parameters:
- ROB_IDX_W, 5, width of ROB index
- ORDER_W, 64, width of retirement counter

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- head_valid  in  1  ROB head entry valid
- head_done  in  1  ROB head status is done
- head_rob_idx  in  ROB_IDX_W  head index
- head_pc  in  32  head PC
- head_rd_addr  in  5  destination register
- head_rd_data  in  32  result
- head_regf_we  in  1  entry writes rd
- head_is_store  in  1  entry is a store
- head_is_branch  in  1  entry is a branch or jump
- head_br_en  in  1  branch resolved taken
- head_pc_new  in  32  resolved target
- st_commit_ready_i  in  1  store buffer accepts the release
- dequeue_o  out  1  pop ROB head (combinational)
- st_commit_valid_o  out  1  release head store (combinational)
- regf_we_o  out  1  register-file write enable (registered)
- regf_rd_o  out  5  write address (registered)
- regf_data_o  out  32  write data (registered)
- regf_rob_idx_o  out  ROB_IDX_W  retired index, used to clear the RAT tag on a match (registered)
- commit_valid_o  out  1  one retirement happened (registered)
- commit_pc_o  out  32  retired PC (registered)
- order_o  out  ORDER_W  order of the retired instruction (registered)
- flush_o  out  1  flush pulse (registered)
- redirect_pc_o  out  32  fetch redirect target, valid with flush_o

## Operation
- FSM states: RUN, STORE_WAIT, FLUSH. Reset state is RUN.
- An entry is retireable when head_valid && head_done and the FSM is in RUN.
- Retiring a non-store:
  - assert dequeue_o in the same cycle;
  - on the next edge, register the regfile write and the commit outputs.
- Retiring a store:
  - assert st_commit_valid_o in the same cycle.
  - If st_commit_ready_i is also high, assert dequeue_o in that cycle and retire.
  - Otherwise go to STORE_WAIT.
- STORE_WAIT:
  - hold st_commit_valid_o high, keep dequeue_o low, ignore new head information;
  - on the cycle st_commit_ready_i is high, assert dequeue_o, retire, and return to RUN.
- Regfile write: regf_we_o = head_regf_we && !head_is_store && head_rd_addr != 0. A write to x0 is suppressed but the entry still retires.
- Mispredict: a retireable head with head_is_branch && head_br_en retires normally, including the rd write for jal/jalr, and the FSM moves to FLUSH.
  - flush_o and redirect_pc_o = head_pc_new are registered, so they are asserted in the cycle after dequeue.
- FLUSH lasts exactly one cycle, the cycle flush_o is high.
  - No retirement is allowed, since the head still shows stale younger entries.
  - The FSM then returns to RUN.
- order_o: the value presented with commit_valid_o. It starts at 0 and the internal counter increments by 1 per retirement, wrapping modulo 2^ORDER_W.
- At most one retirement per cycle.

## Timing
- Reset (asynchronous): every registered output = 0, order counter = 0, FSM = RUN.
  - dequeue_o and st_commit_valid_o are 0 while rst is high.
  - Reset during STORE_WAIT drops st_commit_valid_o immediately. The store is not released.
- Latency: head done at cycle N gives dequeue_o at N; regf/commit outputs at N+1; flush_o at N+1 when mispredicted.
- Registered outputs are single-cycle pulses and deassert the following cycle unless another retirement occurs.
- ROB interaction: the ROB pops on the edge ending cycle N, so the new head is visible at N+1 and may retire at N+1. Back-to-back retirement gives one retirement per cycle.
- Store handshake: a transfer occurs when valid && ready. st_commit_valid_o never drops before the transfer, and head fields must stay stable while waiting.
- Mispredicted store: not possible; a store is never a branch.
- head_valid with !head_done: no outputs; the FSM stays in its state.

## Test plan
- Reset then three back-to-back done ALU heads (rd=1,2,3; data 0xA,0xB,0xC): dequeue_o high on 3 consecutive cycles. One cycle later each, regf writes of x1=0xA, x2=0xB, x3=0xC with order_o = 0, 1, 2.
- Done head with rd=0, regf_we=1: dequeue_o=1, regf_we_o=0, commit_valid_o=1, order_o increments.
- Store head with ready low for 4 cycles: st_commit_valid_o high for 5 cycles and dequeue_o only in cycle 5. The following ALU head retires the next cycle; regf_we_o stays 0 for the store.
- jal head (rd=1, data=0x104, br_en=1, pc_new=0x200), followed by a done younger head: x1=0x104 written, flush_o=1 with redirect_pc_o=0x200 for exactly one cycle, and the younger head is not dequeued during the FLUSH cycle.
- Assert rst during STORE_WAIT: st_commit_valid_o and all registered outputs go to 0 asynchronously. After release, the FSM is in RUN with order counter 0.
